// File: rtl/cnn_downsampling_pool.sv
// Stride-4, 4x4 pooling over raster-ordered pixels using a one-row line buffer of partial results.
// Default build is signed max pooling; define DOWNSAMPLING_AVG_EN for mean pooling (sum >>> 4).
`timescale 1ns/1ps

module cnn_downsampling_pool #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32,
    parameter int CHANNEL_NUM  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int LB_DEPTH = IMAGE_WIDTH / 4;
    localparam int COL_W    = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CH_W     = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;
    localparam int LB_IDX_W = (LB_DEPTH     > 1) ? $clog2(LB_DEPTH)     : 1;
`ifdef DOWNSAMPLING_AVG_EN
    // Four guard bits hold the sum of 16 signed pixels without overflow.
    localparam int ENTRY_W  = DATA_WIDTH + 4;
`else
    localparam int ENTRY_W  = DATA_WIDTH;
`endif

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [CH_W-1:0]     ch;

    logic                col_last;
    logic                row_last;
    logic                ch_last;
    logic                block_first;
    logic                block_last;
    logic                frame_last;
    logic [LB_IDX_W-1:0] lb_idx;

    logic signed [ENTRY_W-1:0] line_buf [LB_DEPTH];
    logic signed [ENTRY_W-1:0] entry_rd;
    logic signed [ENTRY_W-1:0] pxl_ext;
    logic signed [ENTRY_W-1:0] entry_new;
    logic signed [ENTRY_W-1:0] entry_wr;
    logic [DATA_WIDTH-1:0]     pool_out;

    assign col_last    = (col == COL_W'(IMAGE_WIDTH - 1));
    assign row_last    = (row == ROW_W'(IMAGE_HEIGHT - 1));
    assign ch_last     = (ch  == CH_W'(CHANNEL_NUM - 1));
    assign block_first = (row[1:0] == 2'd0) && (col[1:0] == 2'd0);
    assign block_last  = (row[1:0] == 2'd3) && (col[1:0] == 2'd3);
    assign frame_last  = col_last && row_last && ch_last;
    assign lb_idx      = LB_IDX_W'(col >> 2);

    assign entry_rd    = line_buf[lb_idx];

`ifdef DOWNSAMPLING_AVG_EN
    assign pxl_ext     = {{4{pxl_in[DATA_WIDTH-1]}}, pxl_in};
    assign entry_new   = entry_rd + pxl_ext;
    // Dropping the low four bits of a signed sum is an arithmetic shift, i.e. floor of the mean.
    assign pool_out    = entry_new[ENTRY_W-1:4];
`else
    assign pxl_ext     = pxl_in;
    assign entry_new   = (pxl_ext > entry_rd) ? pxl_ext : entry_rd;
    assign pool_out    = entry_new;
`endif

    // The first pixel of a block overwrites the entry, so stale data from earlier planes never leaks.
    assign entry_wr    = block_first ? pxl_ext : entry_new;

    always_ff @(posedge clk) begin
        if (valid_in) begin
            line_buf[lb_idx] <= entry_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    ch  <= ch_last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= valid_in && block_last;
            frame_done <= valid_in && block_last && frame_last;
            if (valid_in && block_last) begin
                pxl_out <= pool_out;
            end
        end
    end

endmodule

// File: tb/tb_cnn_downsampling_pool.sv
// Directed bench for cnn_downsampling_pool on an 8x8x2 frame; expectations follow DOWNSAMPLING_AVG_EN.
`timescale 1ns/1ps

module tb_cnn_downsampling_pool;

    localparam int DW    = 16;
    localparam int IW    = 8;
    localparam int IH    = 8;
    localparam int CN    = 2;
    localparam int FRAME = IW * IH * CN;
    localparam int NOUT  = (IW / 4) * (IH / 4) * CN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          frame_done;

    logic drv_last;
    logic drv_flast;
    logic exp_v;
    logic exp_fd;

    int tests = 0;
    int fails = 0;
    int outq[$];
    int fd_at[$];
    logic signed [31:0] held;

`ifdef DOWNSAMPLING_AVG_EN
    int exp_ramp[NOUT] = '{13, 17, 45, 49, 77, 81, 109, 113};
`else
    int exp_ramp[NOUT] = '{27, 31, 59, 63, 91, 95, 123, 127};
`endif

    always #5 clk = ~clk;

    cnn_downsampling_pool #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH),
        .CHANNEL_NUM (CN)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .valid_in  (valid_in),
        .pxl_in    (pxl_in),
        .pxl_out   (pxl_out),
        .valid_out (valid_out),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Expected pulses: one cycle after the driver presents the 16th pixel of a block.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v  <= 1'b0;
            exp_fd <= 1'b0;
        end else begin
            exp_v  <= valid_in && drv_last;
            exp_fd <= valid_in && drv_flast;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 0;
        end else begin
            check("valid_out_timing", {31'b0, valid_out}, {31'b0, exp_v});
            check("frame_done_timing", {31'b0, frame_done}, {31'b0, exp_fd});
            if (valid_out) begin
                held = 32'($signed(pxl_out));
                outq.push_back(held);
                if (frame_done) fd_at.push_back(outq.size());
            end else begin
                check("pxl_out_hold", 32'($signed(pxl_out)), held);
            end
        end
    end

    task automatic send(input int idx, input logic signed [DW-1:0] v);
        int c;
        int r;
        c = idx % IW;
        r = (idx / IW) % IH;
        pxl_in    = v;
        valid_in  = 1'b1;
        drv_last  = (c % 4 == 3) && (r % 4 == 3);
        drv_flast = (idx % FRAME) == FRAME - 1;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        drv_last  = 1'b0;
        drv_flast = 1'b0;
        pxl_in    = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_results();
        outq.delete();
        fd_at.delete();
    endtask

    task automatic check_frames(input string tag, input int nfr, input int offset2);
        check($sformatf("%s_count", tag), outq.size(), nfr * NOUT);
        for (int i = 0; i < outq.size() && i < nfr * NOUT; i++) begin
            check($sformatf("%s_out%0d", tag, i), outq[i],
                  exp_ramp[i % NOUT] + ((i >= NOUT) ? offset2 : 0));
        end
        check($sformatf("%s_fd_count", tag), fd_at.size(), nfr);
        for (int k = 0; k < fd_at.size() && k < nfr; k++) begin
            check($sformatf("%s_fd_pos%0d", tag, k), fd_at[k], (k + 1) * NOUT);
        end
        clear_results();
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        pxl_in    = '0;
        drv_last  = 1'b0;
        drv_flast = 1'b0;
        #23;
        check("reset_pxl_out", 32'($signed(pxl_out)), 0);
        check("reset_valid_out", {31'b0, valid_out}, 0);
        check("reset_frame_done", {31'b0, frame_done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Continuous ramp 0..127.
        for (int i = 0; i < FRAME; i++) send(i, DW'(i));
        idle(3);
        check_frames("ramp", 1, 0);

        // Per-block pattern: max build has one +3 among -5s, avg build is all -1.
        for (int i = 0; i < FRAME; i++) begin
            int c;
            int r;
            int b;
            logic signed [DW-1:0] v;
            c = i % IW;
            r = (i / IW) % IH;
            b = (i / (IW * IH)) * 4 + (r / 4) * 2 + c / 4;
`ifdef DOWNSAMPLING_AVG_EN
            v = -16'sd1;
`else
            v = ((r % 4 == b % 4) && (c % 4 == (b * 3) % 4)) ? 16'sd3 : -16'sd5;
`endif
            send(i, v);
        end
        idle(3);
        check("pattern_count", outq.size(), NOUT);
        for (int i = 0; i < outq.size() && i < NOUT; i++) begin
`ifdef DOWNSAMPLING_AVG_EN
            check($sformatf("pattern_out%0d", i), outq[i], -1);
`else
            check($sformatf("pattern_out%0d", i), outq[i], 3);
`endif
        end
        check("pattern_fd_count", fd_at.size(), 1);
        clear_results();

        // Ramp with alternating single-cycle gaps and random 0-5 cycle gaps.
        for (int i = 0; i < FRAME; i++) begin
            send(i, DW'(i));
            idle((i % 2 == 0) ? 1 : int'($urandom_range(0, 5)));
        end
        idle(3);
        check_frames("gapped", 1, 0);

        // Abandon a frame after 40 pixels, then resend a full ramp.
        for (int i = 0; i < 40; i++) send(i, DW'(i));
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_pxl_out", 32'($signed(pxl_out)), 0);
        check("midreset_valid_out", {31'b0, valid_out}, 0);
        check("midreset_frame_done", {31'b0, frame_done}, 0);
        idle(2);
        rst_n = 1'b1;
        clear_results();
        idle(1);
        for (int i = 0; i < FRAME; i++) send(i, DW'(i));
        idle(3);
        check_frames("after_reset", 1, 0);

        // Two frames back-to-back, second offset by 1000.
        for (int i = 0; i < 2 * FRAME; i++) begin
            send(i, (i < FRAME) ? DW'(i) : DW'(i - FRAME + 1000));
        end
        idle(3);
        check_frames("two_frames", 2, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
